ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single-clock `ram` block (one write port, one read port, `DEPTH` x `DATA_WIDTH`) between requesters A and B. Each requester issues read or write commands over a req/gnt handshake. Writes are arbitrated onto the RAM write port and reads onto the RAM read port, each with its own round-robin pointer, so one write and one read can be granted in the same cycle. Read data is returned to the requester that issued the read, tagged by a registered owner bit. The block sits between the requesters and the `ram` instance.

---
 rtl/ram_arbiter.sv | 139 +++++++++++++
 tb/tb_ram_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Shares one single-clock dual-port RAM (one write port, one read port)
// between two requesters, A and B. Writes and reads are arbitrated
// independently, each with its own round-robin pointer, so a write from one
// requester and a read from the other can both be granted in the same cycle.
// Read data comes back one cycle after the read grant and is routed to the
// requester that issued the read, using a registered owner bit.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata requester A command (we: 1 = write, 0 = read)
//   a_gnt                     A command accepted this cycle (combinational)
//   a_rvalid/a_rdata          A read return, one cycle after the read grant
//   b_*                       same set for requester B
//   wr_enb/wr_addr/wr_data    RAM write port
//   rd_enb/rd_addr            RAM read port
//   rd_data                   RAM registered read data
//
// Handshake: a command is presented while x_req is high and completes on a
// cycle where x_req && x_gnt. Until granted, the requester keeps we, addr and
// wdata stable; it may drop req before the grant, and then nothing is issued.
// x_gnt never depends on rd_data.

module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  wr_enb,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_enb,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  // Round-robin pointers (0 = A preferred, 1 = B preferred) and read return.
  logic wr_prio;
  logic rd_prio;
  logic rd_pend;
  logic rd_owner;

  // Per-requester command classes.
  logic a_wr, a_rd, b_wr, b_rd;
  // Arbitration results.
  logic wr_sel_b, rd_sel_b;
  logic a_wgnt, b_wgnt, a_rgnt, b_rgnt;
  logic wr_any, rd_any;

  always_comb begin
    a_wr = a_req &  a_we;
    a_rd = a_req & ~a_we;
    b_wr = b_req &  b_we;
    b_rd = b_req & ~b_we;

    // B wins a port when it is the only contender or when the pointer
    // favours it; otherwise A wins whenever it asks.
    wr_sel_b = b_wr & (~a_wr | wr_prio);
    rd_sel_b = b_rd & (~a_rd | rd_prio);

    a_wgnt = ~rst & a_wr & ~wr_sel_b;
    b_wgnt = ~rst & b_wr &  wr_sel_b;
    a_rgnt = ~rst & a_rd & ~rd_sel_b;
    b_rgnt = ~rst & b_rd &  rd_sel_b;

    wr_any = a_wgnt | b_wgnt;
    rd_any = a_rgnt | b_rgnt;

    a_gnt = a_wgnt | a_rgnt;
    b_gnt = b_wgnt | b_rgnt;
  end

  // RAM drive: zero address/data whenever the port is not granted.
  always_comb begin
    wr_enb  = wr_any;
    wr_addr = '0;
    wr_data = '0;
    rd_enb  = rd_any;
    rd_addr = '0;
    if (a_wgnt) begin
      wr_addr = a_addr;
      wr_data = a_wdata;
    end else if (b_wgnt) begin
      wr_addr = b_addr;
      wr_data = b_wdata;
    end
    if (a_rgnt) begin
      rd_addr = a_addr;
    end else if (b_rgnt) begin
      rd_addr = b_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_prio  <= 1'b0;
      rd_prio  <= 1'b0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      // After a grant the pointer moves to the requester that lost
      // (or did not ask): A won -> prefer B, B won -> prefer A.
      if (wr_any) begin
        wr_prio <= ~wr_sel_b;
      end
      if (rd_any) begin
        rd_prio  <= ~rd_sel_b;
        rd_owner <= rd_sel_b;
      end
      rd_pend <= rd_any;
    end
  end

  // Gating with rst drops a read that was granted the cycle before reset,
  // since rd_pend is still set during that reset cycle.
  always_comb begin
    a_rvalid = rd_pend & ~rd_owner & ~rst;
    b_rvalid = rd_pend &  rd_owner & ~rst;
    a_rdata  = rd_data;
    b_rdata  = rd_data;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter. Contains a behavioural model of the RAM it
// arbitrates for (registered read, old data on same-address write/read,
// memory and read data cleared by reset). Each table row is one clock cycle:
// inputs are driven just after the falling edge and outputs are compared 1ns
// later, well away from the rising edge.

module tb_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          wr_enb, rd_enb;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // RAM model
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_enb) mem[wr_addr] <= wr_data;
      if (rd_enb) rd_data <= mem[rd_addr];
    end
  end

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Vector table
  typedef struct {
    logic          rst;
    logic          a_req, a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_req, b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          e_agnt, e_bgnt;
    logic          e_wen;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic          e_ren;
    logic [AW-1:0] e_raddr;
    logic          e_arv, e_brv;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  // Driver tasks
  task automatic drive(input vec_t v);
    @(negedge clk);
    rst     = v.rst;
    a_req   = v.a_req;  a_we = v.a_we;  a_addr = v.a_addr;  a_wdata = v.a_wdata;
    b_req   = v.b_req;  b_we = v.b_we;  b_addr = v.b_addr;  b_wdata = v.b_wdata;
    #1;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("row%0d", idx);
    chk({t, " a_gnt"},    32'(a_gnt),    32'(v.e_agnt));
    chk({t, " b_gnt"},    32'(b_gnt),    32'(v.e_bgnt));
    chk({t, " wr_enb"},   32'(wr_enb),   32'(v.e_wen));
    chk({t, " wr_addr"},  32'(wr_addr),  32'(v.e_waddr));
    chk({t, " wr_data"},  32'(wr_data),  32'(v.e_wdata));
    chk({t, " rd_enb"},   32'(rd_enb),   32'(v.e_ren));
    chk({t, " rd_addr"},  32'(rd_addr),  32'(v.e_raddr));
    chk({t, " a_rvalid"}, 32'(a_rvalid), 32'(v.e_arv));
    chk({t, " b_rvalid"}, 32'(b_rvalid), 32'(v.e_brv));
    if (v.e_arv) chk({t, " a_rdata"}, 32'(a_rdata), 32'(v.e_rdata));
    if (v.e_brv) chk({t, " b_rdata"}, 32'(b_rdata), 32'(v.e_rdata));
  endtask

  initial begin
    vec_t idle_v;
    idle_v = vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0, 0,0,0};

    //                rst A:req we addr wdata  B:req we addr wdata  gntA B  wen wa wd   ren ra  arv brv rdata
    // Reset with requests pending, then idle reset
    vecs.push_back(vec_t'{1, 1,1,4'h3,8'h5A, 1,0,4'h0,8'h00, 0,0, 0,4'h0,8'h00, 0,4'h0, 0,0,8'h00});
    vecs.push_back(vec_t'{1, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,0, 0,4'h0,8'h00, 0,4'h0, 0,0,8'h00});
    // A writes 0x5A to 3, reads it back
    vecs.push_back(vec_t'{0, 1,1,4'h3,8'h5A, 0,0,4'h0,8'h00, 1,0, 1,4'h3,8'h5A, 0,4'h0, 0,0,8'h00});
    vecs.push_back(vec_t'{0, 1,0,4'h3,8'h00, 0,0,4'h0,8'h00, 1,0, 0,4'h0,8'h00, 1,4'h3, 0,0,8'h00});
    vecs.push_back(vec_t'{0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,0, 0,4'h0,8'h00, 0,4'h0, 1,0,8'h5A});
    vecs.push_back(idle_v);
    // B single write (moves write pointer back to A)
    vecs.push_back(vec_t'{0, 0,0,4'h0,8'h00, 1,1,4'h6,8'h66, 0,1, 1,4'h6,8'h66, 0,4'h0, 0,0,8'h00});
    // Write contention: A, B, A, B
    vecs.push_back(vec_t'{0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 1,0, 1,4'h1,8'h11, 0,4'h0, 0,0,8'h00});
    vecs.push_back(vec_t'{0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 0,1, 1,4'h2,8'h22, 0,4'h0, 0,0,8'h00});
    vecs.push_back(vec_t'{0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 1,0, 1,4'h1,8'h11, 0,4'h0, 0,0,8'h00});
    vecs.push_back(vec_t'{0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 0,1, 1,4'h2,8'h22, 0,4'h0, 0,0,8'h00});
    // Readback of addresses 1 and 2
    vecs.push_back(vec_t'{0, 1,0,4'h1,8'h00, 0,0,4'h0,8'h00, 1,0, 0,4'h0,8'h00, 1,4'h1, 0,0,8'h00});
    vecs.push_back(vec_t'{0, 0,0,4'h0,8'h00, 1,0,4'h2,8'h00, 0,1, 0,4'h0,8'h00, 1,4'h2, 1,0,8'h11});
    vecs.push_back(vec_t'{0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,0, 0,4'h0,8'h00, 0,4'h0, 0,1,8'h22});
    // A writes 0x77 to 5 while B reads 5: old data, then new data
    vecs.push_back(vec_t'{0, 1,1,4'h5,8'h77, 1,0,4'h5,8'h00, 1,1, 1,4'h5,8'h77, 1,4'h5, 0,0,8'h00});
    vecs.push_back(vec_t'{0, 0,0,4'h0,8'h00, 1,0,4'h5,8'h00, 0,1, 0,4'h0,8'h00, 1,4'h5, 0,1,8'h00});
    vecs.push_back(vec_t'{0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,0, 0,4'h0,8'h00, 0,4'h0, 0,1,8'h77});
    // Preload address 0 = 0xA0, address 1 = 0xB1
    vecs.push_back(vec_t'{0, 1,1,4'h0,8'hA0, 0,0,4'h0,8'h00, 1,0, 1,4'h0,8'hA0, 0,4'h0, 0,0,8'h00});
    vecs.push_back(vec_t'{0, 0,0,4'h0,8'h00, 1,1,4'h1,8'hB1, 0,1, 1,4'h1,8'hB1, 0,4'h0, 0,0,8'h00});
    // Read contention: grants alternate, rvalid alternates, never both
    vecs.push_back(vec_t'{0, 1,0,4'h0,8'h00, 1,0,4'h1,8'h00, 1,0, 0,4'h0,8'h00, 1,4'h0, 0,0,8'h00});
    vecs.push_back(vec_t'{0, 1,0,4'h0,8'h00, 1,0,4'h1,8'h00, 0,1, 0,4'h0,8'h00, 1,4'h1, 1,0,8'hA0});
    vecs.push_back(vec_t'{0, 1,0,4'h0,8'h00, 1,0,4'h1,8'h00, 1,0, 0,4'h0,8'h00, 1,4'h0, 0,1,8'hB1});
    vecs.push_back(vec_t'{0, 1,0,4'h0,8'h00, 1,0,4'h1,8'h00, 0,1, 0,4'h0,8'h00, 1,4'h1, 1,0,8'hA0});
    // A writes 0x44 to 4 (write pointer now favours B)
    vecs.push_back(vec_t'{0, 1,1,4'h4,8'h44, 0,0,4'h0,8'h00, 1,0, 1,4'h4,8'h44, 0,4'h0, 0,1,8'hB1});
    // A read of 4 granted (read pointer now favours B), then reset
    vecs.push_back(vec_t'{0, 1,0,4'h4,8'h00, 0,0,4'h0,8'h00, 1,0, 0,4'h0,8'h00, 1,4'h4, 0,0,8'h00});
    vecs.push_back(vec_t'{1, 1,0,4'h4,8'h00, 1,0,4'h0,8'h00, 0,0, 0,4'h0,8'h00, 0,4'h0, 0,0,8'h00});
    // After reset both pointers favour A; memory is cleared
    vecs.push_back(vec_t'{0, 1,0,4'h4,8'h00, 1,0,4'h0,8'h00, 1,0, 0,4'h0,8'h00, 1,4'h4, 0,0,8'h00});
    vecs.push_back(vec_t'{0, 1,1,4'h7,8'h01, 1,1,4'h8,8'h02, 1,0, 1,4'h7,8'h01, 0,4'h0, 1,0,8'h00});
    vecs.push_back(idle_v);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check_vec(i, vecs[i]);
    end

    // Single requester streaming: A writes 10..13, then reads them back-to-back
    for (int i = 0; i < 4; i++) begin
      vec_t w;
      w = idle_v;
      w.a_req = 1'b1; w.a_we = 1'b1; w.a_addr = AW'(10 + i); w.a_wdata = DW'(8'hC0 + i);
      drive(w);
      chk($sformatf("stream_wr%0d a_gnt", i), 32'(a_gnt), 32'd1);
    end
    for (int i = 0; i < 6; i++) begin
      vec_t r;
      r = idle_v;
      if (i < 4) begin
        r.a_req = 1'b1; r.a_we = 1'b0; r.a_addr = AW'(10 + i);
      end
      drive(r);
      if (i >= 1 && i <= 4) begin
        chk($sformatf("stream_rd%0d a_rvalid", i), 32'(a_rvalid), 32'd1);
        if (exp_q.size() > 0) begin
          chk($sformatf("stream_rd%0d a_rdata", i), 32'(a_rdata), 32'(exp_q.pop_front()));
        end else begin
          chk($sformatf("stream_rd%0d queue", i), 32'(exp_q.size()), 32'd1);
        end
      end else begin
        chk($sformatf("stream_rd%0d a_rvalid", i), 32'(a_rvalid), 32'd0);
      end
      chk($sformatf("stream_rd%0d b_rvalid", i), 32'(b_rvalid), 32'd0);
      if (i < 4) begin
        chk($sformatf("stream_rd%0d a_gnt", i), 32'(a_gnt), 32'd1);
        exp_q.push_back(DW'(8'hC0 + i));
      end
    end
    chk("stream queue drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
